// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for an in-order pipeline with DEPTH tracked post-ID stages.
// Produces EX forward selects, load-use stalls, the IF/ID flush and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              branch_taken_i,
  output logic [FWD_W-1:0]  ex_rs1_fwd_o,
  output logic [FWD_W-1:0]  ex_rs2_fwd_o,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [DEPTH-1:0]  vld_q, vld_d, wr_q, wr_d, ld_q, ld_d;
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [REG_AW-1:0] rd_d [DEPTH];
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic              ex_rs1_used_q, ex_rs1_used_d, ex_rs2_used_q, ex_rs2_used_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0]  prod_ok, id1_hit, id2_hit, ex1_hit, ex2_hit, ld_hit;
  logic              stall;
  logic              advance;

  // Per-stage producer matching against the ID sources and the EX sources.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign prod_ok[gi] = vld_q[gi] & wr_q[gi] & (rd_q[gi] != '0);
    assign id1_hit[gi] = prod_ok[gi] & id_rs1_used_i & (rd_q[gi] == id_rs1_i);
    assign id2_hit[gi] = prod_ok[gi] & id_rs2_used_i & (rd_q[gi] == id_rs2_i);
    assign ex1_hit[gi] = prod_ok[gi] & ex_rs1_used_q & (rd_q[gi] == ex_rs1_q);
    assign ex2_hit[gi] = prod_ok[gi] & ex_rs2_used_q & (rd_q[gi] == ex_rs2_q);
    // A load is not yet forwardable while its data would arrive after the consumer's EX.
    assign ld_hit[gi]  = (gi + 1 < LOAD_STAGE) & ld_q[gi] & (id1_hit[gi] | id2_hit[gi]);
  end

  assign stall   = id_valid_i & (|ld_hit);
  assign advance = id_valid_i & ~stall;

  always_comb begin
    ex_rs1_fwd_o = '0;
    ex_rs2_fwd_o = '0;
    // Scan oldest to youngest so the youngest matching producer overwrites.
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (ex1_hit[k]) ex_rs1_fwd_o = FWD_W'(k);
      if (ex2_hit[k]) ex_rs2_fwd_o = FWD_W'(k);
    end
  end

  assign stall_o       = stall;
  assign pc_write_o    = ~stall;
  assign ifid_write_o  = ~stall;
  assign idex_bubble_o = stall;
  assign ifid_flush_o  = branch_taken_i & ~stall;
  assign stall_cnt_o   = stall_cnt_q;

  always_comb begin
    vld_d         = {vld_q[DEPTH-2:0], advance};
    wr_d          = {wr_q[DEPTH-2:0], advance & id_regwrite_i};
    ld_d          = {ld_q[DEPTH-2:0], advance & id_memread_i};
    rd_d[0]       = advance ? id_rd_i : '0;
    for (int k = 1; k < DEPTH; k++) rd_d[k] = rd_q[k-1];
    ex_rs1_d      = advance ? id_rs1_i : '0;
    ex_rs2_d      = advance ? id_rs2_i : '0;
    ex_rs1_used_d = advance & id_rs1_used_i;
    ex_rs2_used_d = advance & id_rs2_used_i;
    stall_cnt_d   = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q         <= '0;
      wr_q          <= '0;
      ld_q          <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rs1_used_q <= 1'b0;
      ex_rs2_used_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      vld_q         <= vld_d;
      wr_q          <= wr_d;
      ld_q          <= ld_d;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= rd_d[k];
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rs1_used_q <= ex_rs1_used_d;
      ex_rs2_used_q <= ex_rs2_used_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controller instances (3-stage/load@2 and 4-stage/load@3 with a narrow
// stall counter) share one stimulus stream and are checked against an instruction-history model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       u1 = 1'b0, u2 = 1'b0, wr = 1'b0, ld = 1'b0, br = 1'b0;

  logic [1:0]  f1_0, f2_0, f1_1, f2_1;
  logic        st_0, pcw_0, ifw_0, fl_0, bub_0;
  logic        st_1, pcw_1, ifw_1, fl_1, bub_1;
  logic [15:0] cnt_0;
  logic [2:0]  cnt_1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_STAGE(2), .FWD_W(2), .CNT_W(16)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .id_rd_i(rd), .id_regwrite_i(wr), .id_memread_i(ld), .branch_taken_i(br),
    .ex_rs1_fwd_o(f1_0), .ex_rs2_fwd_o(f2_0), .stall_o(st_0), .pc_write_o(pcw_0),
    .ifid_write_o(ifw_0), .ifid_flush_o(fl_0), .idex_bubble_o(bub_0), .stall_cnt_o(cnt_0)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(4), .LOAD_STAGE(3), .FWD_W(2), .CNT_W(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .id_rd_i(rd), .id_regwrite_i(wr), .id_memread_i(ld), .branch_taken_i(br),
    .ex_rs1_fwd_o(f1_1), .ex_rs2_fwd_o(f2_1), .stall_o(st_1), .pc_write_o(pcw_1),
    .ifid_write_o(ifw_1), .ifid_flush_o(fl_1), .idex_bubble_o(bub_1), .stall_cnt_o(cnt_1)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rd, rs1, rs2;
    logic       wr, ld, u1, u2;
  } ins_t;

  typedef struct packed {
    logic        chk;
    logic [1:0]  f1, f2;
    logic        st, pcw, ifw, fl, bub;
    logic [15:0] cnt;
  } exp_t;

  // Model: hist[i][k] is the instruction that entered EX k cycles ago (k=0 is in EX now).
  ins_t hist [2][4];
  int   mcnt [2];
  bit   known = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic int depth_of(input int i);
    return (i == 0) ? 3 : 4;
  endfunction

  function automatic int lstage_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic bit writes(input ins_t p, input logic [4:0] src, input logic used);
    return used && p.v && p.wr && (p.rd != 5'd0) && (p.rd == src);
  endfunction

  function automatic exp_t model_out(input int i, input ins_t id, input bit brt);
    exp_t e;
    ins_t ex;
    bit   s;
    s = 1'b0;
    if (id.v)
      for (int j = 0; j < depth_of(i); j++)
        if ((j + 1 < lstage_of(i)) && hist[i][j].ld &&
            (writes(hist[i][j], id.rs1, id.u1) || writes(hist[i][j], id.rs2, id.u2)))
          s = 1'b1;
    ex = hist[i][0];
    e.f1 = 2'd0;
    e.f2 = 2'd0;
    if (ex.v)
      for (int k = 1; k < depth_of(i); k++) begin
        if (e.f1 == 2'd0 && writes(hist[i][k], ex.rs1, ex.u1)) e.f1 = 2'(k);
        if (e.f2 == 2'd0 && writes(hist[i][k], ex.rs2, ex.u2)) e.f2 = 2'(k);
      end
    e.chk = known;
    e.st  = s;
    e.pcw = ~s;
    e.ifw = ~s;
    e.bub = s;
    e.fl  = brt & ~s;
    e.cnt = 16'(mcnt[i]);
    return e;
  endfunction

  task automatic model_clock(input int i, input ins_t id, input bit r, input bit s);
    ins_t nop;
    int   maxc;
    nop  = '0;
    maxc = (i == 0) ? 65535 : 7;
    if (r) begin
      for (int k = 0; k < 4; k++) hist[i][k] = nop;
      mcnt[i] = 0;
    end else begin
      for (int k = 3; k >= 1; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = (id.v && !s) ? id : nop;
      if (s && mcnt[i] < maxc) mcnt[i] = mcnt[i] + 1;
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [4:0] a, input logic [4:0] b,
                      input bit ua, input bit ub, input logic [4:0] d, input bit w,
                      input bit l, input bit brt);
    ins_t id;
    exp_t e0, e1;
    rst = r; id_valid = v; rs1 = a; rs2 = b; u1 = ua; u2 = ub;
    rd = d; wr = w; ld = l; br = brt;
    id.v = v; id.rd = d; id.rs1 = a; id.rs2 = b; id.wr = w; id.ld = l; id.u1 = ua; id.u2 = ub;
    e0 = model_out(0, id, brt);
    e1 = model_out(1, id, brt);
    q0.push_back(e0);
    q1.push_back(e1);
    model_clock(0, id, r, e0.st);
    model_clock(1, id, r, e1.st);
    if (r) known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmp(input string name, input int inst, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, inst, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are combinational on registered state, so every cycle presents a response.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      if (e.chk) begin
        cmp("rs1_fwd", 0, 16'(f1_0), 16'(e.f1));
        cmp("rs2_fwd", 0, 16'(f2_0), 16'(e.f2));
        cmp("stall", 0, 16'(st_0), 16'(e.st));
        cmp("pc_write", 0, 16'(pcw_0), 16'(e.pcw));
        cmp("ifid_write", 0, 16'(ifw_0), 16'(e.ifw));
        cmp("ifid_flush", 0, 16'(fl_0), 16'(e.fl));
        cmp("idex_bubble", 0, 16'(bub_0), 16'(e.bub));
        cmp("stall_cnt", 0, cnt_0, e.cnt);
        $display("cyc %0d dut0 fwd=%0d/%0d stall=%0d flush=%0d cnt=%0d", cyc, f1_0, f2_0,
                 st_0, fl_0, cnt_0);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      if (e.chk) begin
        cmp("rs1_fwd", 1, 16'(f1_1), 16'(e.f1));
        cmp("rs2_fwd", 1, 16'(f2_1), 16'(e.f2));
        cmp("stall", 1, 16'(st_1), 16'(e.st));
        cmp("pc_write", 1, 16'(pcw_1), 16'(e.pcw));
        cmp("ifid_write", 1, 16'(ifw_1), 16'(e.ifw));
        cmp("ifid_flush", 1, 16'(fl_1), 16'(e.fl));
        cmp("idex_bubble", 1, 16'(bub_1), 16'(e.bub));
        cmp("stall_cnt", 1, 16'(cnt_1), e.cnt);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset then idle.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    // add x5 ; sub x6,x5,x7 back to back.
    step(0, 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    step(0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0);
    idle(4);
    // add x5 ; independent ; sub x6,x5,x7.
    step(0, 1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    step(0, 1, 5'd3, 5'd4, 1, 1, 5'd9, 1, 0, 0);
    step(0, 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0);
    idle(4);
    // lw x5 ; add x8,x5,x5 held in ID while it stalls.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd5, 5'd5, 1, 1, 5'd8, 1, 0, 0);
    idle(5);
    // Taken beq with no hazard.
    step(0, 1, 5'd10, 5'd11, 1, 1, 5'd0, 0, 0, 1);
    idle(2);
    // lw x5 ; beq x5,x6 taken, held in ID during the stall.
    step(0, 1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd5, 5'd6, 1, 1, 5'd0, 0, 0, 1);
    idle(4);
    // addi x0,x0,1 ; consumer of x0; also lw x0 ; consumer of x0.
    step(0, 1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0);
    step(0, 1, 5'd0, 5'd0, 1, 1, 5'd3, 1, 0, 0);
    step(0, 1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 0);
    step(0, 1, 5'd0, 5'd0, 1, 1, 5'd3, 1, 0, 0);
    idle(3);
    // Reset asserted during a stall.
    step(0, 1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1, 0);
    step(1, 1, 5'd5, 5'd5, 1, 1, 5'd8, 1, 0, 0);
    idle(4);
    // Random traffic on a small register set to provoke hazards, x0 and saturation.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
    end
    idle(2);
    for (int i = 0; i < 10; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d/%0d responses never observed, expected 0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order pipelined CPU; replaces the separate fixed 5-stage hazard detection and forwarding units.
- Keeps a shadow pipeline of DEPTH post-ID stage entries (index 0 = EX … DEPTH-1 = last write-back stage) with destination, write and load flags.
- Generates EX-operand forward selects, load-use stall (configurable load latency), ID-resolved branch flush of IF/ID, and a saturating stall counter.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after ID (≥2).
- LOAD_STAGE, 2, first stage index whose entry can forward load data (1..DEPTH-1).
- FWD_W, 2, forward-select width; must satisfy 2^FWD_W ≥ DEPTH.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i, id_rs2_i  in  REG_AW  ID source registers.
- id_rs1_used_i, id_rs2_used_i  in  1  source actually read.
- id_rd_i  in  REG_AW  ID destination.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_memread_i  in  1  ID instruction is a load.
- branch_taken_i  in  1  branch in ID resolved taken.
- ex_rs1_fwd_o, ex_rs2_fwd_o  out  FWD_W  0 = register-file value, k = forward from stage k.
- stall_o  out  1  load-use stall this cycle.
- pc_write_o  out  1  PC may update.
- ifid_write_o  out  1  IF/ID may load.
- ifid_flush_o  out  1  squash IF/ID contents.
- idex_bubble_o  out  1  load NOP into ID/EX.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Entry fields: valid, rd, regwrite, memread; entry 0 additionally holds rs1, rs2, rs1_used, rs2_used.
- Reset (rising clk with rst_i=1): all entries invalid; stall_cnt_o=0. Outputs then read fwd=0, stall_o=0, pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0. Reset mid-stall or mid-flush clears immediately, with no residual bubble.
- Shift each cycle: entry[k] ← entry[k-1] for k≥1. Entry[0] ← ID fields when id_valid_i=1 and stall_o=0; otherwise entry[0] becomes invalid (bubble). Entry[DEPTH-1] falls off.
- Hazard match of a source s against entry k: entry valid, regwrite=1, rd==s, rd≠0, and the source's used flag is 1.
- Forward select (combinational, EX): for each EX source, pick the smallest k in 1..DEPTH-1 that matches. Return k, else 0. The youngest producer wins.
- Load-use stall (combinational): stall_o=1 when id_valid_i=1 and an ID source matches an entry j with memread=1 and j+1 < LOAD_STAGE, counting entry[0] as j=0. With the defaults, a load in EX stalls a dependent ID instruction for exactly 1 cycle. LOAD_STAGE=3 with DEPTH=4 gives 2 stall cycles.
- During stall_o=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. Otherwise all three are 1, 1, 0.
- Flush: ifid_flush_o = branch_taken_i & ~stall_o. The branch itself still advances into entry[0]. When stall and branch_taken are both high, the stall wins, the flush is suppressed, and the branch is re-evaluated next cycle.
- Register-file write in stage DEPTH-1 is covered by the forward select. After an entry falls off, the register file holds the value, so select 0 is correct.
- stall_cnt_o increments by 1 on each stall_o=1 cycle and holds at 2^CNT_W-1.
- x0: rd=0 never matches, so fwd is 0 and no stall occurs.

Test Plan:
- Reset, then idle with id_valid_i=0 for 5 cycles -> all fwd=0, stall_o=0, pc_write_o=1, stall_cnt_o=0.
- Back-to-back add x5 then sub x6,x5,x7 -> when sub reaches EX, ex_rs1_fwd_o=1, ex_rs2_fwd_o=0. With one independent instruction between them -> ex_rs1_fwd_o=2.
- lw x5 followed by add x8,x5,x5 (defaults) -> stall_o=1 for exactly 1 cycle with idex_bubble_o=1 and pc_write_o=0. Then add in EX sees both fwd=2; stall_cnt_o=1.
- DEPTH=4, LOAD_STAGE=3, lw x5 then dependent add -> 2 consecutive stall cycles, then fwd=3; stall_cnt_o=2.
- Taken beq with no hazard -> ifid_flush_o=1 for 1 cycle. beq depending on a load in EX with branch_taken_i=1 -> ifid_flush_o=0 during the stall, then 1 the next cycle.
- addi x0,x0,1 followed by an instruction reading x0 -> fwd=0, no stall. Also assert rst_i during a stall -> next cycle stall_o=0, entries empty, stall_cnt_o=0.
